clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run/stop and divisor-reconfiguration controller for the divided core clock (clk_out).
//  Generates clk_out from iCLK with a programmable half-period.
//  Accepts new divisors over a valid/ready handshake and applies them only at a full-period boundary.
//  Starts and stops without runt pulses. Sits between the host config regs and the hash-core clock domain.
// PARAMETERS
//  CNT_W        4  width of the divisor and of the internal counter; legal divisors 1..2^CNT_W-1
//  DEFAULT_DIV  4  half-period in iCLK cycles loaded at reset (must be nonzero)
// PORTS
//  iCLK        in   1      system clock; single clock domain
//  RST_N       in   1      reset, asynchronous assert, active-low
//  cfg_valid   in   1      new divisor offered
//  cfg_div     in   CNT_W  half-period in iCLK cycles (0 = illegal)
//  cfg_ready   out  1      controller can accept a divisor
//  run_req     in   1      level: 1 = clock should run, 0 = stop
//  clk_out     out  1      divided clock, registered
//  clk_rise    out  1      1 in the first iCLK cycle that clk_out is high
//  running     out  1      state != IDLE
//  cfg_err     out  1      one-cycle pulse: a zero divisor was rejected
//  div_active  out  CNT_W  divisor currently in effect
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, counter=0, clk_out=0, clk_rise=0, running=0, cfg_err=0,
//    div_active=DEFAULT_DIV, pend_vld=0, cfg_ready=1. Reset mid-run kills clk_out immediately.
//  Handshake: transfer when cfg_valid & cfg_ready. cfg_ready = !pend_vld (registered).
//    cfg_div==0: transfer completes; cfg_err=1 next cycle; no state change.
//    cfg_div!=0: pend_div<=cfg_div, pend_vld<=1.
//  Apply rule: pend_div is loaded into div_active, counter<=0, pend_vld<=0 when either:
//    - state==IDLE (one cycle after acceptance), or
//    - a boundary occurs: counter==div_active-1 with clk_out==1 (the falling toggle).
//    The period in progress always completes with the old divisor.
//  States:
//    IDLE  -> RUN   : run_req=1. Counter=0, clk_out=0 on entry.
//    RUN            : each cycle counter++. At counter==div_active-1: counter<=0, clk_out<=~clk_out.
//    RUN   -> IDLE  : run_req=0 while clk_out==0. Counter<=0; clk_out stays 0.
//    RUN   -> DRAIN : run_req=0 while clk_out==1.
//    DRAIN          : counts as RUN.
//    DRAIN -> IDLE  : at the falling toggle. clk_out<=0.
//    DRAIN -> RUN   : run_req=1 again. No counter disturbance.
//  Timing: run_req first sampled 1 at edge k (IDLE) -> RUN from k.
//    clk_out rises at edge k+div_active; period = 2*div_active iCLK cycles.
//    Duty cycle is 50%. A high phase is never shortened.
//  clk_rise: registered; asserted exactly in cycles where clk_out transitions 0->1.
//  div_active=1: clk_out toggles every cycle (iCLK/2).
//  Counter compare uses div_active-1 in CNT_W bits; no wrap beyond div_active-1 can occur.
// TESTING
//  1 Reset then run_req=1 with DEFAULT_DIV=4
//      -> first clk_out rise 4 cycles after RUN entry; period 8; clk_rise one cycle per period.
//  2 While running div 4, send cfg_div=2 mid high phase
//      -> cfg_ready drops; current period finishes at 8; next periods are 4; div_active=2 at the boundary.
//  3 cfg_div=0 accepted
//      -> cfg_err pulse 1 cycle; div_active unchanged; cfg_ready stays 1.
//  4 Drop run_req during the high phase
//      -> high phase completes full length, clk_out=0, running=0 at the toggle.
//      Drop during the low phase -> IDLE next cycle.
//  5 Drop then re-raise run_req inside DRAIN
//      -> clk_out waveform identical to an uninterrupted run.
//  6 Assert RST_N=0 asynchronously mid high phase
//      -> clk_out=0 immediately; all outputs at reset values; div_active=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop and divisor-reconfiguration controller for the
// divided core clock. It produces a 50% duty clock whose half-period is
// div_active iCLK cycles. New divisors arrive over a valid/ready handshake
// and take effect only at a full-period boundary (the falling toggle) or
// while idle. Start and stop never produce a runt pulse.
module clk_div_ctrl #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             iCLK,
    input  logic             RST_N,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             run_req,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             running,
    output logic             cfg_err,
    output logic [CNT_W-1:0] div_active
);

    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_ZERO    = '0;
    localparam logic [CNT_W-1:0] LP_DEFAULT = CNT_W'(DEFAULT_DIV);

    // IDLE: clock parked low. RUN: clock toggling. DRAIN: stop requested
    // while high, so the high phase is allowed to finish at full length.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clk;
    logic             w_clk_nxt;
    logic             r_rise;

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_pend_div;
    logic [CNT_W-1:0] w_pend_div_nxt;
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [CNT_W-1:0] w_div_m1;
    logic             w_last;
    logic             w_boundary;
    logic             w_apply;
    logic             w_xfer;

    // The counter never exceeds div_active-1, so reaching it marks the end
    // of the current half-period. A boundary is the end of a high phase.
    assign w_div_m1   = r_div - LP_ONE;
    assign w_last     = (r_cnt == w_div_m1);
    assign w_boundary = (r_state != ST_IDLE) && w_last && r_clk;
    assign w_apply    = r_pend_vld && ((r_state == ST_IDLE) || w_boundary);
    assign w_xfer     = cfg_valid && !r_pend_vld;

    // Next-state and waveform decision: counting, toggling and stop handling.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clk_nxt   = r_clk;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = LP_ZERO;
                w_clk_nxt = 1'b0;
                if (run_req) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!run_req && !r_clk) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = LP_ZERO;
                    w_clk_nxt   = 1'b0;
                end else begin
                    if (w_last) begin
                        w_cnt_nxt = LP_ZERO;
                        w_clk_nxt = !r_clk;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                    if (!run_req) begin
                        w_state_nxt = w_last ? ST_IDLE : ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_last) begin
                    w_cnt_nxt   = LP_ZERO;
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = run_req ? ST_RUN : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                    if (run_req) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = LP_ZERO;
                w_clk_nxt   = 1'b0;
            end
        endcase

        if (w_apply) begin
            w_cnt_nxt = LP_ZERO;
        end
    end

    // Divisor handshake: park a nonzero divisor as pending, flag zero ones.
    always_comb begin
        w_div_nxt      = r_div;
        w_pend_div_nxt = r_pend_div;
        w_pend_vld_nxt = r_pend_vld;
        w_err_nxt      = 1'b0;

        if (w_apply) begin
            w_div_nxt      = r_pend_div;
            w_pend_vld_nxt = 1'b0;
        end

        if (w_xfer) begin
            if (cfg_div == LP_ZERO) begin
                w_err_nxt = 1'b1;
            end else begin
                w_pend_div_nxt = cfg_div;
                w_pend_vld_nxt = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge iCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, divided clock and its rise marker; reset kills the clock at once.
    always_ff @(posedge iCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= LP_ZERO;
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_clk  <= w_clk_nxt;
            r_rise <= w_clk_nxt && !r_clk;
        end
    end

    // Active/pending divisor registers and the zero-divisor error pulse.
    always_ff @(posedge iCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div      <= LP_DEFAULT;
            r_pend_div <= LP_ZERO;
            r_pend_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign cfg_ready  = !r_pend_vld;
    assign clk_out    = r_clk;
    assign clk_rise   = r_rise;
    assign running    = (r_state != ST_IDLE);
    assign cfg_err    = r_err;
    assign div_active = r_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl. A time-based model (half-phases measured in
// elapsed iCLK edges) predicts every output each cycle; directed sequences
// pin rise spacing and handshake behaviour with hand-computed constants.
module tb_clk_div_ctrl;

    localparam int CNT_W       = 4;
    localparam int DEFAULT_DIV = 4;

    logic             iCLK = 1'b0;
    logic             RST_N;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             run_req;
    logic             clk_out;
    logic             clk_rise;
    logic             running;
    logic             cfg_err;
    logic [CNT_W-1:0] div_active;

    int testsRun  = 0;
    int failCount = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .iCLK       (iCLK),
        .RST_N      (RST_N),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .run_req    (run_req),
        .clk_out    (clk_out),
        .clk_rise   (clk_rise),
        .running    (running),
        .cfg_err    (cfg_err),
        .div_active (div_active)
    );

    always #5 iCLK = ~iCLK;

    // Model state: the generator is on/off, sits at a level, and the current
    // half-phase began at edge mPhaseStart; it lasts mDiv edges.
    bit   mActive     = 1'b0;
    bit   mLevel      = 1'b0;
    bit   mRise       = 1'b0;
    bit   mErr        = 1'b0;
    int   mDiv        = DEFAULT_DIV;
    int   mTime       = 0;
    int   mPhaseStart = 0;
    int   mPendQ[$];
    bit   wasActive, wasLevel, due, readyBefore;

    bit   checkEn   = 1'b0;
    bit   prevClk   = 1'b0;
    int   riseCount = 0;
    int   lastRise  = 0;
    int   fallCount = 0;
    int   lastFall  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced once per iCLK edge.
    always @(posedge iCLK or negedge RST_N) begin
        if (!RST_N) begin
            mActive = 1'b0;
            mLevel  = 1'b0;
            mRise   = 1'b0;
            mErr    = 1'b0;
            mDiv    = DEFAULT_DIV;
            mPendQ.delete();
        end else begin
            mTime++;
            wasActive   = mActive;
            wasLevel    = mLevel;
            readyBefore = (mPendQ.size() == 0);
            due         = wasActive && ((mTime - mPhaseStart) == mDiv);
            mErr        = 1'b0;

            if (!wasActive) begin
                if (run_req) begin
                    mActive     = 1'b1;
                    mLevel      = 1'b0;
                    mPhaseStart = mTime;
                end
            end else if (!wasLevel && !run_req) begin
                mActive = 1'b0;
            end else if (due) begin
                mLevel      = !wasLevel;
                mPhaseStart = mTime;
                if (!mLevel && !run_req) mActive = 1'b0;
            end

            if (!readyBefore && (!wasActive || (wasLevel && due))) begin
                mDiv = mPendQ.pop_front();
            end

            if (cfg_valid && readyBefore) begin
                if (cfg_div == 0) mErr = 1'b1;
                else mPendQ.push_back(int'(cfg_div));
            end

            mRise = !wasLevel && mLevel;
        end
    end

    // Per-cycle comparison against the model, plus rise/fall bookkeeping.
    always @(negedge iCLK) begin
        if (checkEn) begin
            checkOutput("m_clk_out",    int'(clk_out),    int'(mLevel));
            checkOutput("m_clk_rise",   int'(clk_rise),   int'(mRise));
            checkOutput("m_running",    int'(running),    int'(mActive));
            checkOutput("m_cfg_err",    int'(cfg_err),    int'(mErr));
            checkOutput("m_cfg_ready",  int'(cfg_ready),  (mPendQ.size() == 0) ? 1 : 0);
            checkOutput("m_div_active", int'(div_active), mDiv);
        end
        if (clk_rise) begin
            riseCount++;
            lastRise = mTime;
        end
        if (prevClk && !clk_out) begin
            fallCount++;
            lastFall = mTime;
        end
        prevClk = clk_out;
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic run, input logic valid, input logic [CNT_W-1:0] div);
        run_req   = run;
        cfg_valid = valid;
        cfg_div   = div;
    endtask

    task automatic waitRise(input string name);
        int start;
        start = riseCount;
        for (int i = 0; i < 40; i++) begin
            stepCycles(1);
            if (riseCount != start) break;
        end
        if (riseCount == start) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic waitFall(input string name);
        int start;
        start = fallCount;
        for (int i = 0; i < 40; i++) begin
            stepCycles(1);
            if (fallCount != start) break;
        end
        if (fallCount == start) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    // Directed sequences.
    initial begin
        int k;
        int prev;

        RST_N = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(3);

        checkOutput("rst_clk_out",  int'(clk_out),    0);
        checkOutput("rst_running",  int'(running),    0);
        checkOutput("rst_ready",    int'(cfg_ready),  1);
        checkOutput("rst_div",      int'(div_active), 4);
        checkOutput("rst_err",      int'(cfg_err),    0);
        checkOutput("rst_rise",     int'(clk_rise),   0);
        checkEn = 1'b1;
        RST_N   = 1'b1;
        stepCycles(2);

        // Start with the default divisor of 4.
        applyStimulus(1'b1, 1'b0, 4'd0);
        k = mTime + 1;
        waitRise("t1_r1");
        checkOutput("first_rise_delay", lastRise - k, 4);
        prev = lastRise;
        waitRise("t1_r2");
        checkOutput("period_div4_a", lastRise - prev, 8);
        prev = lastRise;
        waitRise("t1_r3");
        checkOutput("period_div4_b", lastRise - prev, 8);

        // Divisor 2 offered mid high phase: old high phase finishes (4),
        // then a new low phase of 2, then periods of 4.
        prev = lastRise;
        applyStimulus(1'b1, 1'b1, 4'd2);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("ready_drop", int'(cfg_ready),  0);
        checkOutput("div_hold",   int'(div_active), 4);
        waitRise("t2_r1");
        checkOutput("rise_after_switch", lastRise - prev, 6);
        checkOutput("div_switched", int'(div_active), 2);
        prev = lastRise;
        waitRise("t2_r2");
        checkOutput("period_div2_a", lastRise - prev, 4);
        prev = lastRise;
        waitRise("t2_r3");
        checkOutput("period_div2_b", lastRise - prev, 4);

        // Zero divisor is accepted but rejected with a one-cycle error.
        applyStimulus(1'b1, 1'b1, 4'd0);
        stepCycles(1);
        checkOutput("err_pulse",      int'(cfg_err),    1);
        checkOutput("err_ready",      int'(cfg_ready),  1);
        checkOutput("err_div_same",   int'(div_active), 2);
        applyStimulus(1'b1, 1'b0, 4'd0);
        stepCycles(1);
        checkOutput("err_one_cycle",  int'(cfg_err),    0);

        // Move to divisor 6, then stop during the high phase.
        applyStimulus(1'b1, 1'b1, 4'd6);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitRise("t4_r1");
        waitRise("t4_r2");
        checkOutput("div6_active", int'(div_active), 6);
        prev = lastRise;
        waitRise("t4_r3");
        checkOutput("period_div6", lastRise - prev, 12);
        prev = lastRise;
        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(1);
        checkOutput("drain_running", int'(running), 1);
        checkOutput("drain_high",    int'(clk_out), 1);
        waitFall("t4_fall");
        checkOutput("high_full_len", lastFall - prev, 6);
        checkOutput("stopped_run",   int'(running), 0);
        checkOutput("stopped_clk",   int'(clk_out), 0);

        // Stop during the low phase: idle on the next edge.
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitRise("t4b_r");
        waitFall("t4b_f");
        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(1);
        checkOutput("stop_low_idle", int'(running), 0);
        checkOutput("stop_low_clk",  int'(clk_out), 0);

        // Drop and re-raise run_req inside the drain: waveform undisturbed.
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitRise("t5_r1");
        waitRise("t5_r2");
        prev = lastRise;
        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitRise("t5_r3");
        checkOutput("drain_reraise_period", lastRise - prev, 12);

        // Async reset mid high phase with a divisor pending.
        applyStimulus(1'b1, 1'b1, 4'd3);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("pend_before_reset", int'(cfg_ready), 0);
        checkOutput("high_before_reset", int'(clk_out),   1);
        @(posedge iCLK);
        #3;
        RST_N = 1'b0;
        #1;
        checkOutput("async_clk_out", int'(clk_out),    0);
        checkOutput("async_running", int'(running),    0);
        checkOutput("async_ready",   int'(cfg_ready),  1);
        checkOutput("async_div",     int'(div_active), 4);
        checkOutput("async_rise",    int'(clk_rise),   0);
        checkOutput("async_err",     int'(cfg_err),    0);
        stepCycles(2);
        RST_N = 1'b1;
        k = mTime + 1;
        waitRise("t6_r");
        checkOutput("post_reset_first_rise", lastRise - k, 4);

        // Divisor 1 loaded while idle: iCLK/2 output.
        applyStimulus(1'b0, 1'b0, 4'd0);
        waitFall("t7_f");
        applyStimulus(1'b0, 1'b1, 4'd1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(1);
        checkOutput("idle_apply_div1", int'(div_active), 1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        k = mTime + 1;
        waitRise("t7_r1");
        checkOutput("div1_first_rise", lastRise - k, 1);
        prev = lastRise;
        waitRise("t7_r2");
        checkOutput("period_div1_a", lastRise - prev, 2);
        prev = lastRise;
        waitRise("t7_r3");
        checkOutput("period_div1_b", lastRise - prev, 2);

        // Largest legal divisor, 15.
        applyStimulus(1'b1, 1'b1, 4'd15);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        waitRise("t8_r1");
        waitRise("t8_r2");
        prev = lastRise;
        waitRise("t8_r3");
        checkOutput("period_div15", lastRise - prev, 30);
        checkOutput("div15_active", int'(div_active), 15);

        applyStimulus(1'b0, 1'b0, 4'd0);
        stepCycles(40);
        checkOutput("final_idle", int'(running), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
